// File: rtl/adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : adder_pkg
// Brief  : Shared processor constants and helpers for the branch-target adder
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package adder_pkg;

  // Default datapath width of the processor
  localparam int ADDER_WIDTH = 32;

  // Width of one carry-lookahead block
  localparam int CLA_W = 4;

  // Signed overflow: operands agree in sign but the result does not
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_cla4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cla4
// Brief  : 4-bit carry-lookahead block exporting group propagate/generate
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module cla4
  import adder_pkg::*;
(
  input  logic [CLA_W-1:0] a,
  input  logic [CLA_W-1:0] b,
  input  logic             cin,
  output logic [CLA_W-1:0] s,
  output logic             gp,
  output logic             gg
);

  logic [CLA_W-1:0] p;
  logic [CLA_W-1:0] g;
  logic [CLA_W-1:0] c;

  // Bit propagate/generate, flat lookahead carries and group terms
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    s    = p ^ c;
    gp   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : adder
// Brief  : Branch-target adder PC_2 + B with a registered result stage
//          (target, carry, signed overflow, valid). WIDTH must be a
//          multiple of the 4-bit lookahead block width.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] PC_2,
  input  logic [WIDTH-1:0] B,
  input  logic             en,
  output logic [WIDTH-1:0] BrA,
  output logic [WIDTH-1:0] BrA_q,
  output logic             C_q,
  output logic             V_q,
  output logic             valid_q
);

  localparam int NB = WIDTH / CLA_W;

  logic [NB:0]    carry;
  logic [NB-1:0]  blk_p;
  logic [NB-1:0]  blk_g;
  logic [WIDTH-1:0] sum;
  logic           carry_out;
  logic           ovf;
  logic           acc;
  logic           prop;

  // One lookahead block per 4-bit slice
  for (genvar i = 0; i < NB; i++) begin : g_cla
    cla4 u_cla4 (
      .a   (PC_2[CLA_W*i +: CLA_W]),
      .b   (B[CLA_W*i +: CLA_W]),
      .cin (carry[i]),
      .s   (sum[CLA_W*i +: CLA_W]),
      .gp  (blk_p[i]),
      .gg  (blk_g[i])
    );
  end

  // Second-level lookahead: each block carry-in is a flat sum of products
  // of the group generate/propagate terms below it (overall carry-in is 0)
  always_comb begin
    carry = '0;
    acc   = 1'b0;
    prop  = 1'b1;
    for (int i = 0; i < NB; i++) begin
      acc  = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prop & blk_g[j]);
        prop = prop & blk_p[j];
      end
      carry[i+1] = acc;
    end
  end

  // Combinational outputs of the adder core
  always_comb begin
    BrA       = sum;
    carry_out = carry[NB];
    ovf       = signed_ovf(PC_2[WIDTH-1], B[WIDTH-1], sum[WIDTH-1]);
  end

  // Registered stage: load on en, hold otherwise; valid tracks en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BrA_q   <= '0;
      C_q     <= 1'b0;
      V_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        BrA_q <= BrA;
        C_q   <= carry_out;
        V_q   <= ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_adder
// Brief  : Directed and random self-checking bench for adder
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC_2;
  logic [31:0] B;
  logic        en;
  logic [31:0] BrA;
  logic [31:0] BrA_q;
  logic        C_q;
  logic        V_q;
  logic        valid_q;

  int passed = 0;
  int total  = 0;

  adder #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .PC_2    (PC_2),
    .B       (B),
    .en      (en),
    .BrA     (BrA),
    .BrA_q   (BrA_q),
    .C_q     (C_q),
    .V_q     (V_q),
    .valid_q (valid_q)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; PC_2 = 32'd3; B = 32'd4;
    #2 rst_n = 1'b0;
    #1;
    total++; if (BrA_q !== 32'h0) $display("FAIL rst_braq got %h want %h", BrA_q, 32'h0); else passed++;
    total++; if ({C_q, V_q, valid_q} !== 3'b000) $display("FAIL rst_flags got %b want 000", {C_q, V_q, valid_q}); else passed++;
    total++; if (BrA !== 32'd7) $display("FAIL rst_bra got %h want %h", BrA, 32'd7); else passed++;
    en = 1'b1;
    tick();
    total++; if (valid_q !== 1'b0) $display("FAIL rst_hold_valid got %b want 0", valid_q); else passed++;
    en = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    PC_2 = 32'h0; B = 32'h0; en = 1'b1;
    #1;
    total++; if (BrA !== 32'h0) $display("FAIL zero_bra got %h want %h", BrA, 32'h0); else passed++;
    tick();
    en = 1'b0;
    total++; if (BrA_q !== 32'h0) $display("FAIL zero_braq got %h want %h", BrA_q, 32'h0); else passed++;
    total++; if ({C_q, V_q} !== 2'b00) $display("FAIL zero_cv got %b want 00", {C_q, V_q}); else passed++;
    total++; if (valid_q !== 1'b1) $display("FAIL zero_valid got %b want 1", valid_q); else passed++;
    tick();
    total++; if (valid_q !== 1'b0) $display("FAIL zero_valid_drop got %b want 0", valid_q); else passed++;
  endtask

  task automatic test_neg_wrap();
    PC_2 = 32'd12; B = 32'hFFFF_FFF4; en = 1'b1;
    #1;
    total++; if (BrA !== 32'h0) $display("FAIL negwrap_bra got %h want %h", BrA, 32'h0); else passed++;
    tick();
    en = 1'b0;
    total++; if (BrA_q !== 32'h0) $display("FAIL negwrap_braq got %h want %h", BrA_q, 32'h0); else passed++;
    total++; if ({C_q, V_q} !== 2'b10) $display("FAIL negwrap_cv got %b want 10", {C_q, V_q}); else passed++;
    // Small backward branch that does not cross zero
    PC_2 = 32'd100; B = 32'hFFFF_FFF6; en = 1'b1;
    tick();
    en = 1'b0;
    total++; if (BrA_q !== 32'd90) $display("FAIL negback_braq got %h want %h", BrA_q, 32'd90); else passed++;
    total++; if ({C_q, V_q} !== 2'b10) $display("FAIL negback_cv got %b want 10", {C_q, V_q}); else passed++;
  endtask

  task automatic test_overflow();
    PC_2 = 32'h7FFF_FFFF; B = 32'd1; en = 1'b1;
    #1;
    total++; if (BrA !== 32'h8000_0000) $display("FAIL ovf_pos_bra got %h want %h", BrA, 32'h8000_0000); else passed++;
    tick();
    total++; if (BrA_q !== 32'h8000_0000) $display("FAIL ovf_pos_braq got %h want %h", BrA_q, 32'h8000_0000); else passed++;
    total++; if ({C_q, V_q} !== 2'b01) $display("FAIL ovf_pos_cv got %b want 01", {C_q, V_q}); else passed++;
    PC_2 = 32'h8000_0000; B = 32'h8000_0000;
    tick();
    en = 1'b0;
    total++; if (BrA_q !== 32'h0) $display("FAIL ovf_neg_braq got %h want %h", BrA_q, 32'h0); else passed++;
    total++; if ({C_q, V_q, valid_q} !== 3'b111) $display("FAIL ovf_neg_cvv got %b want 111", {C_q, V_q, valid_q}); else passed++;
  endtask

  task automatic test_carry_hold();
    PC_2 = 32'hFFFF_FFFF; B = 32'd1; en = 1'b1;
    tick();
    en = 1'b0;
    total++; if (BrA_q !== 32'h0) $display("FAIL carry_braq got %h want %h", BrA_q, 32'h0); else passed++;
    total++; if ({C_q, V_q} !== 2'b10) $display("FAIL carry_cv got %b want 10", {C_q, V_q}); else passed++;
    B = 32'd7;
    #1;
    total++; if (BrA !== 32'd6) $display("FAIL hold_bra got %h want %h", BrA, 32'd6); else passed++;
    tick();
    total++; if (BrA_q !== 32'h0) $display("FAIL hold_braq got %h want %h", BrA_q, 32'h0); else passed++;
    total++; if ({C_q, V_q, valid_q} !== 3'b100) $display("FAIL hold_flags got %b want 100", {C_q, V_q, valid_q}); else passed++;
  endtask

  task automatic test_async_reset();
    PC_2 = 32'd100; B = 32'd5; en = 1'b1;
    tick();
    en = 1'b0;
    total++; if (BrA_q !== 32'd105) $display("FAIL areset_load got %h want %h", BrA_q, 32'd105); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (BrA_q !== 32'h0) $display("FAIL areset_braq got %h want %h", BrA_q, 32'h0); else passed++;
    total++; if ({C_q, V_q, valid_q} !== 3'b000) $display("FAIL areset_flags got %b want 000", {C_q, V_q, valid_q}); else passed++;
    total++; if (BrA !== 32'd105) $display("FAIL areset_bra got %h want %h", BrA, 32'd105); else passed++;
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    en = 1'b0;
    total++; if (BrA_q !== 32'd105) $display("FAIL areset_reload got %h want %h", BrA_q, 32'd105); else passed++;
  endtask

  task automatic test_random();
    logic [32:0] ref_sum;
    logic        v_exp;
    int          errs;
    errs = 0;
    en = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      PC_2 = $urandom;
      B    = $urandom;
      if (n % 8 == 0) B = {{16{B[15]}}, B[15:0]};
      ref_sum = {1'b0, PC_2} + {1'b0, B};
      v_exp   = (PC_2[31] == B[31]) && (ref_sum[31] != PC_2[31]);
      tick();
      if (errs < 8) begin
        total++;
        if ({BrA_q, C_q, V_q} !== {ref_sum[31:0], ref_sum[32], v_exp}) begin
          $display("FAIL rand_%0d got %h/%b/%b want %h/%b/%b (PC_2=%h B=%h)",
                   n, BrA_q, C_q, V_q, ref_sum[31:0], ref_sum[32], v_exp, PC_2, B);
          errs++;
        end else passed++;
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_neg_wrap();
    test_overflow();
    test_carry_hold();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
